dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder: the target end of the memory-stage load/store interface. It accepts one load or store request at a time over a valid/ready handshake, waits a fixed, parameterised number of cycles, and commits the store or performs the load. Loads are byte/half/word with sign or zero extension; stores use byte-lane enables. It replaces the zero-latency data RAM when the pipeline is built with a stall-capable memory stage; `req_ready` low is the stage's stall source.

## Interface

- `WIDTH`, 32: data and address width.
- `ADDR_WIDTH`, 10: word-index bits. Storage is 2^ADDR_WIDTH words.
- `LATENCY`, 2: cycles from request acceptance to response. Legal range is 1 to 15.

- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: responder can accept a request.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, WIDTH: byte address. The word index is `req_addr[ADDR_WIDTH+1:2]`; upper bits are ignored (aliasing).
- `req_wdata`, in, WIDTH: store data, right-aligned.
- `req_size`, in, 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`, in, 1: zero-extend loads when 1, sign-extend when 0.
- `resp_valid`, out, 1: response present.
- `resp_ready`, in, 1: pipeline accepts the response.
- `resp_rdata`, out, WIDTH: load result, extended. Zero for stores and errors.
- `resp_err`, out, 1: misaligned access or reserved size.

## Operation

- FSM states: IDLE, WAIT, RESP. `req_ready` = (state == IDLE), decoded from the state register only.
- IDLE:
  - On `req_valid & req_ready`, latch write, addr, wdata, size and unsigned.
  - Load `cnt <= LATENCY-1`.
  - Go to RESP if LATENCY == 1, else go to WAIT.
- WAIT:
  - `cnt` decrements each cycle.
  - When `cnt == 1`, go to RESP on that edge.
  - On the edge entering RESP, perform the access: store commit, or load sample into the `resp_rdata` register, plus the error flag.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_err` are held stable until `resp_valid & resp_ready`, then go to IDLE.
  - Outputs return to 0 on that same edge.
- Error:
  - Raised when size = 11, when size = half and addr[0] = 1, or when size = word and addr[1:0] ≠ 0.
  - On error, no store commit, `resp_rdata` = 0 and `resp_err` = 1.
- Store lanes:
  - Byte: `wdata[7:0]` is written to lane `addr[1:0]`.
  - Half: `wdata[15:0]` is written to lanes `{addr[1],0}` and `{addr[1],1}`.
  - Word: all four lanes are written.
  - Other lanes are untouched.
- Load extraction:
  - Byte lane `addr[1:0]` or half lane `addr[1]` is shifted to bit 0.
  - Bits above the access width are filled with the access MSB when `req_unsigned` = 0, with 0 otherwise.
  - Word loads ignore `req_unsigned`.
- The store response carries `resp_rdata` = 0 and `resp_err` = 0.
- Storage contents are not reset.

## Timing

- A request is accepted at the end of cycle t. `resp_valid` is first high in cycle t+LATENCY.
- The store commit and load sampling occur at the end of cycle t+LATENCY-1.
- The next request can be accepted no earlier than cycle t+LATENCY+1 (the cycle after the response handshake). Peak throughput is one access per LATENCY+1 cycles.
- A load issued after a store to the same word returns the stored data; the store has already committed.
- Request inputs are ignored outside IDLE; the requester must hold them while `req_ready` is low.
- Reset values: state IDLE, `cnt` 0, `req_ready` 1 once reset deasserts, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0.
- Reset asserted in WAIT discards the pending request. A store not yet committed is never written.
- Reset asserted in RESP drops the response. A store already committed remains in storage.
- `resp_ready` held low keeps the block in RESP indefinitely with outputs stable. `req_ready` stays 0 throughout.
- When `req_valid` and `resp_ready` are both high in RESP, only the response completes. The request is accepted in the following IDLE cycle.

## Test plan

- **Word store/load:** LATENCY = 2. Store word 0xDEADBEEF to 0x40, then load word from 0x40.
  - Store response: `resp_valid` high 2 cycles after acceptance, `resp_err` 0.
  - Load response: `resp_rdata` = 0xDEADBEEF.
- **Byte/half extension:** store word 0x00F08000 to 0x10, then load from it.
  - Signed byte at 0x11 → 0xFFFFFF80.
  - Unsigned byte at 0x11 → 0x00000080.
  - Signed half at 0x12 → 0x000000F0.
  - Byte store of 0xAA to 0x13, then word load → 0xAAF08000.
- **Misalignment and reserved size:**
  - Half store to 0x21 → `resp_err` = 1, `resp_rdata` = 0; a later word load from 0x20 returns the prior contents.
  - Word load from 0x22 → `resp_err` = 1.
  - size = 11 → `resp_err` = 1.
- **Response backpressure:** `resp_ready` low for 3 cycles during a load response.
  - `resp_valid` and `resp_rdata` stay stable for 3 cycles.
  - `req_ready` stays 0 while `req_valid` is held high.
  - The held request is accepted the cycle after the handshake.
- **Reset mid-operation:** assert `rst` during WAIT of a store of 0x12345678 to 0x80, then load 0x80 after reset.
  - Immediately on reset: `resp_valid` 0, `req_ready` 1.
  - The later load returns the pre-store value.
- **Latency sweep:** LATENCY = 1 and LATENCY = 4, with back-to-back requests and `resp_ready` tied high.
  - Response appears exactly LATENCY cycles after acceptance.
  - Request acceptances are spaced exactly LATENCY+1 cycles apart.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the memory stage and its data responder.
interface dmem_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory target: one load/store in flight, byte-lane stores,
// sign/zero-extended loads, misalignment and reserved-size errors.
module dmem_responder #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_cnt;
  logic             r_write, r_uns;
  logic [WIDTH-1:0] r_addr, r_wdata;
  logic [1:0]       r_size;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  logic                  w_write, w_uns, w_err, w_access;
  logic [WIDTH-1:0]      w_addr, w_wdata, w_wword, w_rword, w_ldata;
  logic [1:0]            w_size;
  logic [3:0]            w_be;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused_addr;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req_valid) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt == 4'd1) w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY 1 the access happens on the accepting edge, straight off the bus.
  always_comb begin
    if (r_state == IDLE) begin
      w_write = bus.req_write;  w_addr = bus.req_addr;  w_wdata = bus.req_wdata;
      w_size  = bus.req_size;   w_uns  = bus.req_unsigned;
    end else begin
      w_write = r_write;  w_addr = r_addr;  w_wdata = r_wdata;
      w_size  = r_size;   w_uns  = r_uns;
    end
  end

  assign w_access      = !rst && (w_next == RESP) && (r_state != RESP);
  assign w_idx         = w_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^w_addr[WIDTH-1:ADDR_WIDTH+2];
  assign w_err         = (w_size == 2'b11) || (w_size == 2'b01 && w_addr[0]) ||
                         (w_size == 2'b10 && w_addr[1:0] != 2'b00);

  always_comb begin
    w_be    = 4'b0000;
    w_wword = w_wdata;
    case (w_size)
      2'b00: begin w_be = 4'b0001 << w_addr[1:0]; w_wword = {4{w_wdata[7:0]}}; end
      2'b01: begin w_be = w_addr[1] ? 4'b1100 : 4'b0011; w_wword = {2{w_wdata[15:0]}}; end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_rword = r_mem[w_idx];
  assign w_byte  = 8'(w_rword >> {w_addr[1:0], 3'b000});
  assign w_half  = 16'(w_rword >> {w_addr[1], 4'b0000});

  always_comb begin
    case (w_size)
      2'b00:   w_ldata = {{24{w_byte[7] & ~w_uns}}, w_byte};
      2'b01:   w_ldata = {{16{w_half[15] & ~w_uns}}, w_half};
      default: w_ldata = w_rword;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_access && w_write && !w_err)
      for (int l = 0; l < 4; l++)
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wword[8*l +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= 2'b00;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.req_valid) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_size  <= bus.req_size;
        r_uns   <= bus.req_unsigned;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_write || w_err) ? '0 : w_ldata;
      end else if (r_state == RESP && bus.resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder at LATENCY 2, 1 and 4 against a byte-array model.
module tb_dmem_responder;
  localparam int LAT [3] = '{2, 1, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  vld = 3'b000;
  logic [2:0]  rdy = 3'b111;
  logic        t_write = 1'b0, t_uns = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic [1:0]  t_size = 2'b10;
  logic [2:0]  o_rreq, o_vld, o_err;
  logic [31:0] o_rdata [3];
  logic [7:0]  mm [3][4096];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  dmem_if #(.WIDTH(32)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus[g].req_valid    = vld[g];
    assign bus[g].resp_ready   = rdy[g];
    assign bus[g].req_write    = t_write;
    assign bus[g].req_addr     = t_addr;
    assign bus[g].req_wdata    = t_wdata;
    assign bus[g].req_size     = t_size;
    assign bus[g].req_unsigned = t_uns;
    assign o_rreq[g]  = bus[g].req_ready;
    assign o_vld[g]   = bus[g].resp_valid;
    assign o_rdata[g] = bus[g].resp_rdata;
    assign o_err[g]   = bus[g].resp_err;
  end

  dmem_responder #(.WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus[0]));
  dmem_responder #(.WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus[1]));
  dmem_responder #(.WIDTH(32), .ADDR_WIDTH(10), .LATENCY(4)) dut2 (.clk(clk), .rst(rst), .bus(bus[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: n-byte access on a byte array, 4 KiB address space (upper address bits alias).
  task automatic model(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u, output logic [31:0] rd, output logic er);
    int          n, base;
    logic [31:0] v;
    n    = 1 << sz;
    base = int'(a % 4096);
    er   = (sz == 2'b11) || (a % n != 0);
    rd   = '0;
    v    = '0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) mm[s][base+i] = 8'(wd >> (8*i));
      end else begin
        for (int i = 0; i < n; i++) v = v | (32'(mm[s][base+i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        rd = v;
      end
    end
  endtask

  task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    t_write = w; t_addr = a; t_wdata = wd; t_size = sz; t_uns = u;
    vld[s] = 1'b1;
    n = 0;
    while (!o_rreq[s] && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vld[s] = 1'b0;
    lat = 1;
    while (!o_vld[s] && lat < 100) begin @(posedge clk); #1; lat++; end
    rd = o_rdata[s];
    er = o_err[s];
    @(posedge clk); #1;
  endtask

  task automatic run(input int s, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic u, output logic [31:0] rd);
    logic [31:0] erd;
    logic        eer, er;
    int          lat;
    model(s, w, a, wd, sz, u, erd, eer);
    xact(s, w, a, wd, sz, u, rd, er, lat);
    chk("latency", lat, LAT[s]);
    chk("rdata", rd, erd);
    chk("err", {31'd0, er}, {31'd0, eer});
  endtask

  initial begin
    logic [31:0] rd;
    logic        dummy_er;
    int          acc[$], rsp[$];

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_req_ready", {31'd0, o_rreq[s]}, 32'd1);
      chk("rst_resp_valid", {31'd0, o_vld[s]}, 32'd0);
      chk("rst_rdata", o_rdata[s], 32'd0);
      chk("rst_err", {31'd0, o_err[s]}, 32'd0);
    end

    // word store/load
    run(0, 1'b1, 32'h40, 32'hDEADBEEF, 2'b10, 1'b0, rd);
    run(0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, rd);
    chk("word_load", rd, 32'hDEADBEEF);

    // byte/half extension
    run(0, 1'b1, 32'h10, 32'h00F08000, 2'b10, 1'b0, rd);
    run(0, 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, rd);  chk("sbyte", rd, 32'hFFFFFF80);
    run(0, 1'b0, 32'h11, 32'h0, 2'b00, 1'b1, rd);  chk("ubyte", rd, 32'h00000080);
    run(0, 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd);  chk("shalf", rd, 32'h000000F0);
    run(0, 1'b1, 32'h13, 32'hAA, 2'b00, 1'b0, rd);
    run(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd);  chk("byte_merge", rd, 32'hAAF08000);

    // misalignment and reserved size
    run(0, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, rd);
    run(0, 1'b1, 32'h21, 32'hBEEF, 2'b01, 1'b0, rd);
    run(0, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd);  chk("no_commit_on_err", rd, 32'h11223344);
    run(0, 1'b0, 32'h22, 32'h0, 2'b10, 1'b0, rd);
    run(0, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, rd);

    // response backpressure with a request held behind it
    t_write = 1'b0; t_addr = 32'h40; t_size = 2'b10; t_uns = 1'b0;
    rdy[0] = 1'b0; vld[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_resp_valid", {31'd0, o_vld[0]}, 32'd1);
      chk("bp_rdata", o_rdata[0], 32'hDEADBEEF);
      chk("bp_req_ready", {31'd0, o_rreq[0]}, 32'd0);
      if (c < 2) begin @(posedge clk); #1; end
    end
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", {31'd0, o_rreq[0]}, 32'd1);
    chk("bp_idle_valid", {31'd0, o_vld[0]}, 32'd0);
    chk("bp_idle_rdata", o_rdata[0], 32'd0);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("bp_held_accepted", {31'd0, o_rreq[0]}, 32'd0);
    @(posedge clk); #1;
    chk("bp_second_valid", {31'd0, o_vld[0]}, 32'd1);
    chk("bp_second_rdata", o_rdata[0], 32'hDEADBEEF);
    @(posedge clk); #1;

    // reset during WAIT drops an uncommitted store
    run(0, 1'b1, 32'h80, 32'hCAFEF00D, 2'b10, 1'b0, rd);
    t_write = 1'b1; t_addr = 32'h80; t_wdata = 32'h12345678; t_size = 2'b10;
    vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wait_valid", {31'd0, o_vld[0]}, 32'd0);
    chk("rst_wait_ready", {31'd0, o_rreq[0]}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    run(0, 1'b0, 32'h80, 32'h0, 2'b10, 1'b0, rd);
    chk("rst_wait_old_data", rd, 32'hCAFEF00D);

    // reset during RESP keeps an already committed store
    t_write = 1'b1; t_addr = 32'h84; t_wdata = 32'h5555AAAA; t_size = 2'b10;
    rdy[0] = 1'b0; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_pre", {31'd0, o_vld[0]}, 32'd1);
    model(0, 1'b1, 32'h84, 32'h5555AAAA, 2'b10, 1'b0, rd, dummy_er);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", {31'd0, o_vld[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; rdy[0] = 1'b1;
    run(0, 1'b0, 32'h84, 32'h0, 2'b10, 1'b0, rd);
    chk("rst_resp_kept", rd, 32'h5555AAAA);

    // latency sweep: valid held high, resp_ready high
    for (int s = 1; s < 3; s++) begin
      acc.delete();
      rsp.delete();
      t_write = 1'b1; t_addr = 32'h0; t_wdata = 32'h600D0000 | s; t_size = 2'b10; t_uns = 1'b0;
      vld[s] = 1'b1;
      for (int c = 0; c < 24; c++) begin
        if (o_rreq[s]) acc.push_back(c);
        if (o_vld[s])  rsp.push_back(c);
        @(posedge clk); #1;
      end
      vld[s] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      model(s, 1'b1, 32'h0, 32'h600D0000 | s, 2'b10, 1'b0, rd, dummy_er);
      chk("sweep_acc_count", {31'd0, acc.size() >= 5}, 32'd1);
      chk("sweep_rsp_count", {31'd0, rsp.size() >= 4}, 32'd1);
      if (acc.size() >= 5 && rsp.size() >= 4)
        for (int k = 0; k < 4; k++) begin
          chk("sweep_latency", rsp[k] - acc[k], LAT[s]);
          chk("sweep_spacing", acc[k+1] - acc[k], LAT[s] + 1);
        end
      run(s, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd);
    end

    // random traffic on a pre-initialised window, with aliased upper address bits
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 16; i++)
        run(s, 1'b1, 32'h100 + 4*i, $urandom, 2'b10, 1'b0, rd);
      for (int i = 0; i < 40; i++)
        run(s, 1'($urandom), (32'h100 + ($urandom % 64)) | (($urandom % 4) << 12),
            $urandom, 2'($urandom), 1'($urandom), rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
